// File: rtl/dmem_pkg.sv
// Shared defaults and parameter legality check for the pipelined data memory.
package dmem_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAddrW   = 7;
  localparam int unsigned DefDepth   = 128;
  localparam int unsigned DefLatency = 1;
  // Width of the response down-counter; bounds LATENCY to 15.
  localparam int unsigned CntW       = 4;

  // True when a parameter set can be built.
  function automatic bit params_ok(input int unsigned data_w, input int unsigned addr_w,
                                   input int unsigned depth, input int unsigned latency);
    longint unsigned max_depth;
    if (addr_w < 1 || addr_w > 31) return 1'b0;
    max_depth = 64'd1 << addr_w;
    return (data_w >= 8) && (data_w % 8 == 0) &&
           (depth >= 1) && (longint'(depth) <= max_depth) &&
           (latency >= 1) && (latency <= ((1 << CntW) - 1));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range;

  assign w_in_range = 32'(addr_i) < DEPTH;

  // Byte-lane write; out-of-range addresses never touch the array.
  always_ff @(posedge clk_i) begin
    if (we_i && w_in_range) begin
      for (int k = 0; k < int'(DATA_W / 8); k++) begin
        if (be_i[k]) r_mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = w_in_range ? r_mem[addr_i] : '0;

endmodule

// File: rtl/data_memory_pipe.sv
// Fixed-latency request/response data memory. One request in flight; the
// response cycle can accept the next request, giving one transaction every
// LATENCY cycles.
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned LATENCY = DefLatency
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wData_i,
  output logic                ready_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rData_o,
  output logic                err_o
);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, LATENCY)) begin : g_bad_params
    $error("data_memory_pipe: illegal DATA_W/ADDR_W/DEPTH/LATENCY combination");
  end

  logic                r_busy;
  logic [CntW-1:0]     r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_be;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_resp;
  logic                w_in_range;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rdata;

  assign w_resp     = r_busy && (r_cnt == '0);
  assign ready_o    = !r_busy || (r_cnt == '0);
  assign w_accept   = req_i && ready_o;
  assign w_in_range = 32'(r_addr) < DEPTH;
  // Commit lands on the edge that ends the response cycle.
  assign w_wr_en    = w_resp && r_we && w_in_range;

  // Handshake state: latch on accept, count down, release after the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_busy  <= 1'b1;
      r_cnt   <= CntW'(LATENCY - 1);
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_be    <= be_i;
      r_wdata <= wData_i;
    end else if (r_busy && (r_cnt != '0)) begin
      r_cnt   <= r_cnt - CntW'(1);
    end else if (r_busy) begin
      r_busy  <= 1'b0;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_wr_en),
    .addr_i  (r_addr),
    .be_i    (r_be),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  // Response muxing: data only for in-range reads, error only for out-of-range.
  always_comb begin
    rvalid_o = w_resp;
    rData_o  = '0;
    err_o    = 1'b0;
    if (w_resp) begin
      err_o = !w_in_range;
      if (!r_we && w_in_range) rData_o = w_rdata;
    end
  end

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 7: word-address width.
REQ-003 Parameter DEPTH, default 128: number of words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 Parameter LATENCY, default 1: cycles from accept to response; SHALL be in 1..15.
REQ-005 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 req_i  input  1  request valid.
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 addr_i  input  ADDR_W  word address.
REQ-010 be_i  input  DATA_W/8  byte enables for writes; bit k covers bits 8k+7..8k.
REQ-011 wData_i  input  DATA_W  write data.
REQ-012 ready_o  output  1  block can accept a request this cycle.
REQ-013 rvalid_o  output  1  one-cycle response strobe, for both reads and writes.
REQ-014 rData_o  output  DATA_W  read data; valid only while rvalid_o = 1.
REQ-015 err_o  output  1  response flags an out-of-range address; valid only while rvalid_o = 1.

Function
REQ-016 Accept: a request SHALL be accepted on a rising edge where req_i = 1 and ready_o = 1; we_i, addr_i, be_i and wData_i SHALL be latched on that edge.
REQ-017 State: busy flag plus a 4-bit down-counter cnt; accept SHALL set busy = 1 and cnt = LATENCY-1.
REQ-018 Countdown: while busy = 1 and cnt != 0, cnt SHALL decrement by 1 each cycle.
REQ-019 Response: rvalid_o SHALL equal (busy = 1 and cnt = 0), so it rises exactly LATENCY cycles after the accepting edge and lasts one cycle.
REQ-020 Handshake: ready_o SHALL equal (busy = 0 or cnt = 0); a new accept in the response cycle gives back-to-back operation.
REQ-021 Throughput: LATENCY = 1 SHALL sustain one transaction per cycle; LATENCY = L SHALL sustain one per L cycles.
REQ-022 End of response: busy SHALL clear on the edge ending the response cycle, unless a new request is accepted on that edge.
REQ-023 Read data: rData_o SHALL present mem[latched addr] during the response cycle and SHALL be 0 whenever rvalid_o = 0.
REQ-024 Write commit: the write SHALL commit on the edge ending its response cycle, updating only bytes whose be_i bit was 1.
REQ-025 All-zero be_i: memory SHALL be unchanged, but the write SHALL still be acknowledged.
REQ-026 Write response data: rData_o SHALL be 0 in a write's response cycle.
REQ-027 Read-after-write: a read accepted in or after a write's response cycle SHALL return the committed data; no forwarding path is required.
REQ-028 Out-of-range: if the latched address >= DEPTH, the response SHALL assert err_o = 1 with rData_o = 0, and no write SHALL occur.
REQ-029 err_o SHALL be 0 whenever rvalid_o = 0.
REQ-030 req_i while ready_o = 0 SHALL be ignored and never queued.

Reset
REQ-031 Reset values: busy = 0, cnt = 0, latched fields = 0, so ready_o = 1, rvalid_o = 0, rData_o = 0, err_o = 0.
REQ-032 Reset mid-operation SHALL abort the in-flight transaction: no write commit and no response.
REQ-033 Memory array contents SHALL NOT be reset.
REQ-034 First accept after reset: allowed on the first rising edge after rst_i deasserts.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the default DATA_W, ADDR_W, DEPTH and LATENCY constants and the counter width (4).
REQ-036 Storage SHALL be one sub-module, dmem_array: DEPTH x DATA_W, synchronous byte-enabled write, combinational read.
REQ-037 The top level SHALL hold only the handshake/counter state and the response muxing.
REQ-038 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-039 LATENCY=1: write addr 5, data 0xDEADBEEF, be=0xF; then read addr 5 -> rvalid_o next cycle, rData_o = 0xDEADBEEF, ready_o always 1.
REQ-040 Byte enables: write 0x11223344 be=0xF, then 0xAABBCCDD be=0x5 to addr 3; read addr 3 -> 0x11BB33DD.
REQ-041 LATENCY=3: read accepted at edge N -> ready_o = 0 during N+1..N+2, rvalid_o = 1 only at N+3, ready_o = 1 at N+3; req_i held high during busy is ignored.
REQ-042 DEPTH=100, ADDR_W=7: write addr 120 then read addr 120 -> both responses have err_o = 1 and rData_o = 0; read addr 100-1 is unaffected.
REQ-043 LATENCY=4: write addr 7 = 0xCAFEF00D, assert rst_i at cycle 2 after accept -> no rvalid_o; read addr 7 afterwards returns the pre-write value.
REQ-044 LATENCY=2: back-to-back stream write/read/write/read to addr 9 with req_i high -> one accept every 2 cycles; each read returns the preceding write's data.
